// File: rtl/biphase_pkg.sv
// Shared types and constants for the biphase-mark receive path.
// Interval classes, preamble codes and decoder states.
package biphase_pkg;

    localparam int SUBFRAME_BITS = 28;

    typedef enum logic [1:0] {
        PRE_B = 2'd0,
        PRE_M = 2'd1,
        PRE_W = 2'd2
    } preamble_t;

    typedef enum logic [1:0] {
        IV_SHORT   = 2'd0,
        IV_MED     = 2'd1,
        IV_LONG    = 2'd2,
        IV_INVALID = 2'd3
    } ival_t;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        SYNC = 2'd3
    } state_t;

endpackage

// File: rtl/biphase_interval.sv
// Line synchronizer, edge detector and transition-interval classifier.
// Emits one classified interval per line edge, or INVALID on loss of signal.
module biphase_interval
    import biphase_pkg::*;
#(
    parameter int UI_CLKS = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  line_in,
    output logic  ival_valid,
    output ival_t ival
);

    localparam int SAT = 7 * UI_CLKS / 2;
    localparam int CW  = $clog2(SAT + 1);

    localparam logic [CW-1:0] T_SHORT = CW'(UI_CLKS / 2);
    localparam logic [CW-1:0] T_MED   = CW'(3 * UI_CLKS / 2);
    localparam logic [CW-1:0] T_LONG  = CW'(5 * UI_CLKS / 2);
    localparam logic [CW-1:0] T_SAT   = CW'(SAT);
    localparam logic [CW-1:0] T_PRE   = CW'(SAT - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_s3;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    ival_t         r_ival;

    logic          w_edge;
    logic          w_sat;

    function automatic ival_t classify(input logic [CW-1:0] l);
        if (l < T_SHORT)     return IV_INVALID;
        else if (l < T_MED)  return IV_SHORT;
        else if (l < T_LONG) return IV_MED;
        else if (l < T_SAT)  return IV_LONG;
        else                 return IV_INVALID;
    endfunction

    assign w_edge = r_s2 ^ r_s3;
    // Fires once, on the step into saturation; edges reset it.
    assign w_sat  = !w_edge && (r_cnt == T_PRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ival  <= IV_INVALID;
        end else begin
            r_s1    <= line_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_valid <= w_edge | w_sat;
            r_ival  <= w_edge ? classify(r_cnt) : IV_INVALID;
            if (w_edge)
                r_cnt <= CW'(1);
            else if (r_cnt != T_SAT)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    assign ival_valid = r_valid;
    assign ival       = r_ival;

endmodule

// File: rtl/biphase_decoder.sv
// Biphase-mark subframe decoder: preamble detection, bit recovery,
// 28-bit word assembly with parity status and lock tracking.
module biphase_decoder
    import biphase_pkg::*;
#(
    parameter int UI_CLKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_in,
    output logic [27:0] data_out,
    output logic [1:0]  preamble_out,
    output logic        parity_ok,
    output logic        valid_out,
    output logic        locked,
    output logic        err_out
);

    localparam int NB = SUBFRAME_BITS;

    logic                w_iv_valid;
    ival_t               w_iv;

    state_t              r_state;
    logic [1:0]          r_idx;
    ival_t               r_p1;
    preamble_t           r_pre;
    logic                r_pend;
    logic [4:0]          r_bits;
    logic [NB-1:0]       r_shift;
    logic [NB-1:0]       r_data;
    preamble_t           r_pre_out;
    logic                r_par;
    logic                r_valid;
    logic                r_locked;
    logic                r_err;

    state_t              w_nstate;
    logic [1:0]          w_nidx;
    ival_t               w_np1;
    preamble_t           w_npre;
    logic                w_npend;
    logic [4:0]          w_nbits;
    logic [NB-1:0]       w_nshift;
    logic                w_bit_en;
    logic                w_bit;
    logic                w_done;
    logic                w_err;

    biphase_interval #(
        .UI_CLKS(UI_CLKS)
    ) u_interval (
        .clk        (clk),
        .rst        (rst),
        .line_in    (line_in),
        .ival_valid (w_iv_valid),
        .ival       (w_iv)
    );

    always_comb begin
        w_nstate = r_state;
        w_nidx   = r_idx;
        w_np1    = r_p1;
        w_npre   = r_pre;
        w_npend  = r_pend;
        w_nbits  = r_bits;
        w_nshift = r_shift;
        w_bit_en = 1'b0;
        w_bit    = 1'b0;
        w_done   = 1'b0;
        w_err    = 1'b0;
        if (w_iv_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (w_iv == IV_LONG) begin
                        w_nstate = PRE;
                        w_nidx   = 2'd1;
                    end
                end
                PRE: begin
                    case (r_idx)
                        2'd1: begin
                            if (w_iv == IV_INVALID) begin
                                w_err = 1'b1;
                            end else begin
                                w_np1  = w_iv;
                                w_nidx = 2'd2;
                            end
                        end
                        2'd2: begin
                            if (w_iv != IV_SHORT)
                                w_err = 1'b1;
                            else
                                w_nidx = 2'd3;
                        end
                        default: begin
                            unique case (1'b1)
                                (r_p1 == IV_SHORT && w_iv == IV_LONG):
                                    w_npre = PRE_B;
                                (r_p1 == IV_LONG && w_iv == IV_SHORT):
                                    w_npre = PRE_M;
                                (r_p1 == IV_MED && w_iv == IV_MED):
                                    w_npre = PRE_W;
                                default:
                                    w_err = 1'b1;
                            endcase
                            w_nstate = DATA;
                            w_nbits  = '0;
                            w_npend  = 1'b0;
                        end
                    endcase
                end
                DATA: begin
                    case (w_iv)
                        IV_MED: begin
                            if (r_pend) begin
                                w_err = 1'b1;
                            end else begin
                                w_bit_en = 1'b1;
                                w_bit    = 1'b0;
                            end
                        end
                        IV_SHORT: begin
                            if (r_pend) begin
                                w_bit_en = 1'b1;
                                w_bit    = 1'b1;
                                w_npend  = 1'b0;
                            end else begin
                                w_npend  = 1'b1;
                            end
                        end
                        default: w_err = 1'b1;
                    endcase
                    if (w_bit_en) begin
                        w_nshift = {w_bit, r_shift[NB-1:1]};
                        w_nbits  = r_bits + 5'd1;
                        if (r_bits == 5'(NB - 1)) begin
                            w_done   = 1'b1;
                            w_nstate = SYNC;
                        end
                    end
                end
                SYNC: begin
                    if (w_iv == IV_LONG) begin
                        w_nstate = PRE;
                        w_nidx   = 2'd1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            endcase
        end
        if (w_err) begin
            w_nstate = HUNT;
            w_npend  = 1'b0;
            w_done   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= HUNT;
            r_idx     <= 2'd0;
            r_p1      <= IV_SHORT;
            r_pre     <= PRE_B;
            r_pend    <= 1'b0;
            r_bits    <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_pre_out <= PRE_B;
            r_par     <= 1'b0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_idx   <= w_nidx;
            r_p1    <= w_np1;
            r_pre   <= w_npre;
            r_pend  <= w_npend;
            r_bits  <= w_nbits;
            r_shift <= w_nshift;
            r_valid <= w_done;
            r_err   <= w_err;
            if (w_done) begin
                r_data    <= w_nshift;
                r_pre_out <= r_pre;
                r_par     <= ~(^w_nshift);
                r_locked  <= 1'b1;
            end else if (w_err) begin
                r_locked  <= 1'b0;
            end
        end
    end

    assign data_out     = r_data;
    assign preamble_out = r_pre_out;
    assign parity_ok    = r_par;
    assign valid_out    = r_valid;
    assign locked       = r_locked;
    assign err_out      = r_err;

endmodule

// File: tb/tb_biphase_decoder.sv
// Bench for biphase_decoder: line generator from interval lists,
// subframe-level expectation queue and per-cycle output checker.
module tb_biphase_decoder;

    localparam int UI = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        line_in;
    logic [27:0] data_out;
    logic [1:0]  preamble_out;
    logic        parity_ok;
    logic        valid_out;
    logic        locked;
    logic        err_out;

    always #5 clk = ~clk;

    biphase_decoder #(
        .UI_CLKS(UI)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .line_in      (line_in),
        .data_out     (data_out),
        .preamble_out (preamble_out),
        .parity_ok    (parity_ok),
        .valid_out    (valid_out),
        .locked       (locked),
        .err_out      (err_out)
    );

    typedef struct {
        int          len;
        bit          tag;
        bit          mark;
        logic [27:0] d;
        logic [1:0]  p;
    } iv_t;

    typedef struct {
        int          due;
        logic [27:0] d;
        logic [1:0]  p;
        logic        par;
    } exp_t;

    iv_t         q_iv[$];
    exp_t        q_exp[$];
    logic [29:0] q_cap[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int last_err_cyc = -1;
    int t_mark = 0;
    int t_last = 0;

    logic [27:0] m_data;
    logic [1:0]  m_pre;
    logic        m_par;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     nm, act, req, cyc);
        end
    endtask

    function automatic logic par_of(input logic [27:0] d);
        return ~(^d);
    endfunction

    task automatic push(input int len, input bit tag, input bit mark,
                        input logic [27:0] d, input logic [1:0] p);
        iv_t e;
        e.len = len; e.tag = tag; e.mark = mark; e.d = d; e.p = p;
        q_iv.push_back(e);
    endtask

    task automatic add_pre(input logic [1:0] p);
        int l [4];
        case (p)
            2'd0:    l = '{3, 1, 1, 3};
            2'd1:    l = '{3, 3, 1, 1};
            default: l = '{3, 2, 1, 2};
        endcase
        for (int i = 0; i < 4; i++) push(l[i] * UI, 0, 0, '0, '0);
    endtask

    task automatic add_bits(input logic [27:0] d, input int lo,
                            input int hi, input bit tag,
                            input logic [1:0] p);
        for (int i = lo; i <= hi; i++) begin
            bit t;
            t = tag && (i == 27);
            if (d[i]) begin
                push(UI, 0, 0, d, p);
                push(UI, t, 0, d, p);
            end else begin
                push(2 * UI, t, 0, d, p);
            end
        end
    endtask

    task automatic add_sub(input logic [1:0] p, input logic [27:0] d);
        add_pre(p);
        add_bits(d, 0, 27, 1, p);
    endtask

    task automatic play();
        iv_t  e;
        exp_t x;
        while (q_iv.size() > 0) begin
            e = q_iv.pop_front();
            repeat (e.len) @(negedge clk);
            line_in = ~line_in;
            t_last = cyc;
            if (e.mark) t_mark = cyc;
            if (e.tag) begin
                x.due = cyc + 4; x.d = e.d; x.p = e.p;
                x.par = par_of(e.d);
                q_exp.push_back(x);
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Per-cycle checker, sampled 1 time unit after each rising edge.
    initial begin
        exp_t e;
        m_data = '0; m_pre = '0; m_par = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                m_data = '0; m_pre = '0; m_par = 1'b0;
                chk("rst_valid", {31'd0, valid_out}, 0);
                chk("rst_err", {31'd0, err_out}, 0);
                chk("rst_locked", {31'd0, locked}, 0);
            end else begin
                if (valid_out) begin
                    n_valid++;
                    q_cap.push_back({preamble_out, data_out});
                    chk("valid_err_excl", {31'd0, err_out}, 0);
                    chk("locked_on_valid", {31'd0, locked}, 1);
                    if (q_exp.size() == 0) begin
                        chk("unexpected_valid", {31'd0, valid_out}, 0);
                    end else begin
                        e = q_exp.pop_front();
                        chk("valid_latency", cyc, e.due);
                        m_data = e.d; m_pre = e.p; m_par = e.par;
                    end
                end else if (q_exp.size() > 0 && cyc > q_exp[0].due) begin
                    chk("missing_valid", {31'd0, valid_out}, 1);
                    void'(q_exp.pop_front());
                end
                if (err_out) begin
                    n_err++;
                    last_err_cyc = cyc;
                    chk("locked_on_err", {31'd0, locked}, 0);
                end
            end
            chk("data_out", {4'd0, data_out}, {4'd0, m_data});
            chk("preamble_out", {30'd0, preamble_out}, {30'd0, m_pre});
            chk("parity_ok", {31'd0, parity_ok}, {31'd0, m_par});
        end
    end

    initial begin
        logic [27:0] pay [4];
        logic [1:0]  seq [4];
        logic [27:0] cap0 [4];
        logic [26:0] r;
        logic [26:0] jb;
        logic [27:0] jd;
        int v0, e0, t0;

        seq = '{2'd0, 2'd2, 2'd1, 2'd2};
        rst = 1'b1;
        line_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r = 27'($urandom);
            pay[i] = {^r, r};
        end

        // Reset with line activity
        repeat (3) begin
            @(negedge clk);
            line_in = ~line_in;
        end
        @(negedge clk);
        chk("rst_data_out", {4'd0, data_out}, 0);
        chk("rst_nvalid", n_valid, 0);
        chk("rst_nerr", n_err, 0);
        rst = 1'b0;

        // Clean B subframe: 27 payload bits 0xABCDE5 carry 15 ones,
        // so the even-parity slot 31 bit is 1 -> word 0x8ABCDE5.
        push(UI, 0, 0, '0, '0);
        add_sub(2'd0, 28'h8ABCDE5);
        play();
        wait_cyc(6);
        chk("clean_data", {4'd0, data_out}, 32'h08ABCDE5);
        chk("clean_pre", {30'd0, preamble_out}, 0);
        chk("clean_par", {31'd0, parity_ok}, 1);
        chk("clean_locked", {31'd0, locked}, 1);
        chk("clean_nvalid", n_valid, 1);
        chk("clean_nerr", n_err, 0);
        wait_cyc(40);

        // Parity error after a good subframe
        v0 = n_valid; e0 = n_err;
        push(UI, 0, 0, '0, '0);
        add_sub(2'd0, 28'h8ABCDE5);
        add_sub(2'd1, 28'h0ABCDE5);
        play();
        wait_cyc(6);
        chk("par_data", {4'd0, data_out}, 32'h00ABCDE5);
        chk("par_pre", {30'd0, preamble_out}, 1);
        chk("par_bad", {31'd0, parity_ok}, 0);
        chk("par_locked", {31'd0, locked}, 1);
        chk("par_nerr", n_err - e0, 0);
        chk("par_nvalid", n_valid - v0, 2);
        wait_cyc(40);

        // B W M W in both line polarities
        for (int pol = 0; pol < 2; pol++) begin
            @(negedge clk);
            rst = 1'b1;
            line_in = pol[0];
            wait_cyc(2);
            rst = 1'b0;
            q_cap.delete();
            push(UI, 0, 0, '0, '0);
            for (int k = 0; k < 4; k++) add_sub(seq[k], pay[k]);
            play();
            wait_cyc(6);
            chk("seq_ncap", q_cap.size(), 4);
            for (int k = 0; k < 4 && k < q_cap.size(); k++) begin
                chk("seq_pre", {30'd0, q_cap[k][29:28]}, {30'd0, seq[k]});
                chk("seq_data", {4'd0, q_cap[k][27:0]}, {4'd0, pay[k]});
                if (pol == 0) cap0[k] = q_cap[k][27:0];
                else chk("seq_pol_same", {4'd0, q_cap[k][27:0]},
                         {4'd0, cap0[k]});
            end
            wait_cyc(40);
        end

        // Class boundaries: MED 12/19, SHORT 4+11 and 11+4
        jb = 27'h15A3C4C;
        jd = {^jb, jb};
        v0 = n_valid;
        push(UI, 0, 0, '0, '0);
        add_pre(2'd0);
        push(12, 0, 0, jd, 2'd0);
        push(19, 0, 0, jd, 2'd0);
        push(4, 0, 0, jd, 2'd0);
        push(11, 0, 0, jd, 2'd0);
        push(11, 0, 0, jd, 2'd0);
        push(4, 0, 0, jd, 2'd0);
        add_bits(jd, 4, 27, 1, 2'd0);
        play();
        wait_cyc(6);
        chk("jit_nvalid", n_valid - v0, 1);
        chk("jit_data", {4'd0, data_out}, {4'd0, jd});
        chk("jit_par", {31'd0, parity_ok}, 1);
        wait_cyc(40);

        // 3-clk glitch inside DATA, relock on following subframe
        v0 = n_valid; e0 = n_err;
        push(UI, 0, 0, '0, '0);
        add_sub(2'd0, pay[0]);
        add_pre(2'd0);
        add_bits(28'h0, 0, 4, 0, 2'd0);
        push(6, 0, 0, '0, '0);
        push(3, 0, 1, '0, '0);
        push(7, 0, 0, '0, '0);
        add_bits(28'h0, 6, 27, 0, 2'd0);
        add_sub(2'd1, pay[1]);
        play();
        wait_cyc(6);
        chk("glitch_nerr", n_err - e0, 1);
        chk("glitch_err_cyc", last_err_cyc, t_mark + 4);
        chk("glitch_nvalid", n_valid - v0, 2);
        chk("glitch_relock", {31'd0, locked}, 1);
        wait_cyc(40);

        // Static line inside DATA: one loss-of-signal error
        v0 = n_valid; e0 = n_err;
        push(UI, 0, 0, '0, '0);
        add_sub(2'd0, pay[2]);
        add_pre(2'd2);
        add_bits(pay[3], 0, 9, 0, 2'd2);
        play();
        t0 = t_last;
        push(60, 0, 0, '0, '0);
        push(UI, 0, 0, '0, '0);
        add_sub(2'd2, pay[3]);
        play();
        wait_cyc(6);
        chk("los_nerr", n_err - e0, 1);
        chk("los_err_cyc", last_err_cyc, t0 + 31);
        chk("los_nvalid", n_valid - v0, 2);
        chk("los_relock", {31'd0, locked}, 1);
        wait_cyc(40);

        // Reset mid-DATA discards the partial word
        v0 = n_valid;
        push(UI, 0, 0, '0, '0);
        add_pre(2'd0);
        add_bits(pay[1], 0, 11, 0, 2'd0);
        play();
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        chk("mid_rst_locked", {31'd0, locked}, 0);
        add_bits(pay[1], 12, 27, 0, 2'd0);
        add_sub(2'd1, pay[2]);
        play();
        wait_cyc(6);
        chk("mid_rst_nvalid", n_valid - v0, 1);
        chk("mid_rst_data", {4'd0, data_out}, {4'd0, pay[2]});
        wait_cyc(40);

        chk("exp_drained", q_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
